// File: rtl/stdout_uart_tx_pkg.sv
// Shared types and constants for the stdout UART transmitter.
// Contents: tx_state_t (frame FSM states) and UART_DATA_BITS.
// PARITY is only reached when STDOUT_TX_PARITY_EN is defined.
package stdout_tx_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/stdout_uart_tx_if.sv
// Write-port bundle between the memory-mapped stdout store and the transmitter.
// master (core side): drives wr_en, wr_data; sees full, busy, overflow.
// slave  (transmitter): the reverse.
interface stdout_uart_tx_if;
    import stdout_tx_pkg::*;

    logic                      wr_en;
    logic [UART_DATA_BITS-1:0] wr_data;
    logic                      full;
    logic                      busy;
    logic                      overflow;

    modport master (output wr_en, output wr_data, input full, input busy, input overflow);
    modport slave  (input wr_en, input wr_data, output full, output busy, output overflow);
endinterface

// File: rtl/stdout_uart_tx_byte_fifo.sv
// byte_fifo: synchronous byte FIFO, first-word fall-through read.
// Ports: clk, reset (async, active-low), push/din, pop/dout, full, empty.
// Pushes while full and pops while empty are ignored.
module byte_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [7:0]    r_mem [DEPTH];
    logic          w_push_ok;
    logic          w_pop_ok;

    // Extra wrap bit distinguishes full from empty when the indices match.
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;
    assign dout      = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    // Storage.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/stdout_uart_tx.sv
// stdout_uart_tx: buffers stdout bytes and sends them as UART frames, LSB first.
// Ports: clk, reset (async, active-low), bus (slave: wr_en, wr_data, full,
//        busy, overflow), txd (serial line, idle high, flop-driven).
// Build option STDOUT_TX_PARITY_EN: adds an even-parity bit (8E1); default 8N1.
module stdout_uart_tx
    import stdout_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic              clk,
    input  logic              reset,
    stdout_uart_tx_if.slave   bus,
    output logic              txd
);
    localparam int unsigned BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);

    tx_state_t r_state;
    tx_state_t w_state_nx;
    logic [BW-1:0] r_baud;
    logic [BW-1:0] w_baud_nx;
    logic [2:0]    r_bit;
    logic [2:0]    w_bit_nx;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_nx;
    logic          r_txd;
    logic          w_txd_nx;
    logic          r_ovf;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [7:0]    w_dout;
    logic          w_bit_end;
`ifdef STDOUT_TX_PARITY_EN
    logic          r_par;
    logic          w_par_nx;
`endif

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.wr_en),
        .pop   (w_pop),
        .din   (bus.wr_data),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    assign w_bit_end    = (r_baud == BAUD_LAST);
    assign txd          = r_txd;
    assign bus.full     = w_full;
    assign bus.overflow = r_ovf;
    // Decoded from flops only: work queued or a frame still in flight.
    assign bus.busy     = (r_state != IDLE) || !w_empty;

    // Next-state, baud/bit counters, shifter and line level.
    // txd is registered from the current state, so the line trails the FSM by one cycle.
    always_comb begin
        w_state_nx = r_state;
        w_baud_nx  = r_baud;
        w_bit_nx   = r_bit;
        w_shift_nx = r_shift;
        w_pop      = 1'b0;
        w_txd_nx   = 1'b1;
`ifdef STDOUT_TX_PARITY_EN
        w_par_nx   = r_par;
`endif
        if (r_state != IDLE) w_baud_nx = w_bit_end ? '0 : r_baud + BW'(1);

        case (r_state)
            IDLE: begin
                w_txd_nx = 1'b1;
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_shift_nx = w_dout;
`ifdef STDOUT_TX_PARITY_EN
                    w_par_nx   = ^w_dout;
`endif
                    w_baud_nx  = '0;
                    w_state_nx = START;
                end
            end
            START: begin
                w_txd_nx = 1'b0;
                if (w_bit_end) begin
                    w_bit_nx   = 3'd0;
                    w_state_nx = DATA;
                end
            end
            DATA: begin
                w_txd_nx = r_shift[0];
                if (w_bit_end) begin
                    w_shift_nx = {1'b0, r_shift[7:1]};
                    if (r_bit == BIT_LAST) begin
`ifdef STDOUT_TX_PARITY_EN
                        w_state_nx = PARITY;
`else
                        w_state_nx = STOP;
`endif
                    end else begin
                        w_bit_nx = r_bit + 3'd1;
                    end
                end
            end
`ifdef STDOUT_TX_PARITY_EN
            PARITY: begin
                w_txd_nx = r_par;
                if (w_bit_end) w_state_nx = STOP;
            end
`endif
            STOP: begin
                w_txd_nx = 1'b1;
                if (w_bit_end) begin
                    // Chain straight into the next frame when more bytes wait.
                    if (!w_empty) begin
                        w_pop      = 1'b1;
                        w_shift_nx = w_dout;
`ifdef STDOUT_TX_PARITY_EN
                        w_par_nx   = ^w_dout;
`endif
                        w_state_nx = START;
                    end else begin
                        w_state_nx = IDLE;
                    end
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame and forces the line high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_txd   <= 1'b1;
            r_ovf   <= 1'b0;
`ifdef STDOUT_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nx;
            r_baud  <= w_baud_nx;
            r_bit   <= w_bit_nx;
            r_shift <= w_shift_nx;
            r_txd   <= w_txd_nx;
            r_ovf   <= r_ovf || (bus.wr_en && w_full);
`ifdef STDOUT_TX_PARITY_EN
            r_par   <= w_par_nx;
`endif
        end
    end
endmodule

// File: tb/tb_stdout_uart_tx.sv
// Bench for stdout_uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A queue/timeline model predicts txd, busy, full and overflow each cycle; a
// line decoder recovers bytes from txd for literal checks of each scenario.
// Honours STDOUT_TX_PARITY_EN when it is defined for the build.
module tb_stdout_uart_tx;
    localparam int C     = 4;
    localparam int DEPTH = 4;
`ifdef STDOUT_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FL = FB * C;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic txd;

    stdout_uart_tx_if bus();

    stdout_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus),
        .txd   (txd)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Line level of frame bit slot j for byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
`ifdef STDOUT_TX_PARITY_EN
        if (j == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // ---------------- behavioural model ----------------
    logic [7:0] m_q[$];
    bit         exp_txd[int];
    int         m_e = 0;
    int         m_p = -1;       // edge at which the current frame's byte was taken
    int         m_pre;
    bit         m_pop;
    logic [7:0] m_b;
    logic       m_txd = 1'b1, m_busy = 1'b0, m_full = 1'b0, m_ovf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            exp_txd.delete();
            m_e = 0; m_p = -1;
            m_txd = 1'b1; m_busy = 1'b0; m_full = 1'b0; m_ovf = 1'b0;
        end else begin
            m_e++;
            m_pre = m_q.size();
            // A byte is taken when the line is free or the previous frame ends now.
            m_pop = (m_pre > 0) && (m_p < 0 || m_e >= m_p + FL);
            if (bus.wr_en && m_pre == DEPTH) m_ovf = 1'b1;
            if (m_pop) begin
                m_b = m_q.pop_front();
                m_p = m_e;
                for (int k = 0; k < FL; k++) exp_txd[m_p + 1 + k] = frame_bit(m_b, k / C);
            end
            if (bus.wr_en && m_pre < DEPTH) m_q.push_back(bus.wr_data);
            m_full = (m_q.size() == DEPTH);
            m_busy = (m_q.size() != 0) || (m_p >= 0 && m_e < m_p + FL);
            m_txd  = exp_txd.exists(m_e) ? exp_txd[m_e] : 1'b1;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit cmp_en   = 1'b0;
    int full_cnt = 0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_txd", 32'(txd), 32'(m_txd));
            chk("cyc_busy", 32'(bus.busy), 32'(m_busy));
            chk("cyc_full", 32'(bus.full), 32'(m_full));
            chk("cyc_overflow", 32'(bus.overflow), 32'(m_ovf));
            if (bus.full === 1'b1) full_cnt++;
        end
    end

    // ---------------- line decoder ----------------
    logic [7:0] rx_b [64];
    int         rx_n  = 0;
    int         d_cnt = -1;
    int         d_bi;
    logic [7:0] d_sh  = 8'd0;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_cnt = -1;
        end else if (d_cnt < 0) begin
            if (txd === 1'b0) d_cnt = 0;
        end else begin
            d_cnt++;
            if (d_cnt % C == C / 2) begin
                d_bi = d_cnt / C;
                if (d_bi >= 1 && d_bi <= 8) d_sh[d_bi-1] = txd;
`ifdef STDOUT_TX_PARITY_EN
                if (d_bi == 9) chk("rx_parity", 32'(txd), 32'(^d_sh));
`endif
                if (d_bi == FB - 1) begin
                    chk("rx_stop", 32'(txd), 32'd1);
                    if (rx_n < 64) rx_b[rx_n] = d_sh;
                    rx_n++;
                    d_cnt = -1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic hist [512];

    task automatic wr(input logic [7:0] d);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
    endtask

    // Drops wr_en, then counts busy cycles and records txd while busy.
    task automatic measure(input int limit, output int nbusy, output int first_low);
        nbusy = 0; first_low = -1;
        @(negedge clk);
        bus.wr_en = 1'b0;
        while (bus.busy === 1'b1 && nbusy < limit) begin
            hist[nbusy] = txd;
            if (first_low < 0 && txd === 1'b0) first_low = nbusy;
            nbusy++;
            @(negedge clk);
        end
        if (nbusy >= limit) chk("busy_timeout", 32'(nbusy), 32'(limit - 1));
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (bus.busy === 1'b1 && n < limit) begin
            n++;
            @(negedge clk);
        end
        if (n >= limit) chk("idle_timeout", 32'(n), 32'(limit - 1));
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    int nb, fl, base, f0, lows, bsy;
    int bits41 [8] = '{1, 0, 0, 0, 0, 0, 1, 0};

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        chk("reset_txd", 32'(txd), 32'd1);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_full", 32'(bus.full), 32'd0);
        chk("reset_overflow", 32'(bus.overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte 0x41.
        base = rx_n;
        wr(8'h41);
        measure(300, nb, fl);
        chk("single_busy_cycles", 32'(nb), 32'(FL + 1));
        chk("single_first_low", 32'(fl), 32'd2);
        for (int b = 0; b < 8; b++)
            chk("single_data_bit", 32'(hist[2 + C * (b + 1) + 1]), 32'(bits41[b]));
        chk("single_stop_bit", 32'(hist[2 + C * (FB - 1) + 1]), 32'd1);
        wait_idle(50);
        chk("single_rx_count", 32'(rx_n - base), 32'd1);
        chk("single_rx_byte", 32'(rx_b[base]), 32'h41);
        chk("single_overflow", 32'(bus.overflow), 32'd0);

        // Back-to-back 0x55, 0xAA: counting starts after the second write edge.
        base = rx_n;
        wr(8'h55);
        wr(8'hAA);
        measure(300, nb, fl);
        chk("b2b_busy_cycles", 32'(nb), 32'(2 * FL));
        chk("b2b_first_low", 32'(fl), 32'd1);
        wait_idle(50);
        chk("b2b_rx_count", 32'(rx_n - base), 32'd2);
        chk("b2b_rx_byte0", 32'(rx_b[base]), 32'h55);
        chk("b2b_rx_byte1", 32'(rx_b[base + 1]), 32'hAA);

        // Overflow: seven writes into a four-entry FIFO.
        base = rx_n;
        f0   = full_cnt;
        for (int i = 0; i < 7; i++) wr(8'(i));
        measure(500, nb, fl);
        chk("ovf_flag_set", 32'(bus.overflow), 32'd1);
        chk("ovf_full_seen", 32'(full_cnt > f0), 32'd1);
        wait_idle(100);
        chk("ovf_rx_count", 32'(rx_n - base), 32'd5);
        for (int i = 0; i < 5; i++) chk("ovf_rx_byte", 32'(rx_b[base + i]), 32'(i));
        chk("ovf_sticky", 32'(bus.overflow), 32'd1);

        // Reset during data bit 3 of 0xFF with two bytes queued.
        base = rx_n;
        wr(8'hFF);
        wr(8'h01);
        wr(8'h02);
        @(negedge clk);
        bus.wr_en = 1'b0;
        repeat (17) @(negedge clk);
        chk("rst_mid_busy_before", 32'(bus.busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_txd", 32'(txd), 32'd1);
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_full", 32'(bus.full), 32'd0);
        chk("rst_mid_overflow", 32'(bus.overflow), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        lows = 0; bsy = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
            if (bus.busy !== 1'b0) bsy++;
        end
        chk("rst_mid_quiet_txd", 32'(lows), 32'd0);
        chk("rst_mid_quiet_busy", 32'(bsy), 32'd0);
        chk("rst_mid_rx_count", 32'(rx_n - base), 32'd0);

        // Pointer wrap: 20 paced bytes through a four-entry FIFO.
        base = rx_n;
        f0   = full_cnt;
        for (int i = 0; i < 20; i++) begin
            wr(8'h10 + 8'(i));
            @(negedge clk);
            bus.wr_en = 1'b0;
            repeat (FL) @(negedge clk);
        end
        wait_idle(200);
        chk("wrap_rx_count", 32'(rx_n - base), 32'd20);
        for (int i = 0; i < 20; i++) chk("wrap_rx_byte", 32'(rx_b[base + i]), 32'(8'h10 + 8'(i)));
        chk("wrap_full_never", 32'(full_cnt - f0), 32'd0);
        chk("wrap_overflow", 32'(bus.overflow), 32'd0);

`ifdef STDOUT_TX_PARITY_EN
        // Parity: 0x07 has three ones, so the parity bit is 1.
        base = rx_n;
        wr(8'h07);
        measure(300, nb, fl);
        chk("par_busy_cycles", 32'(nb), 32'd45);
        chk("par_first_low", 32'(fl), 32'd2);
        chk("par_data_bit7", 32'(hist[2 + C * 8 + 1]), 32'd0);
        chk("par_parity_bit", 32'(hist[2 + C * 9 + 1]), 32'd1);
        chk("par_stop_bit", 32'(hist[2 + C * 10 + 1]), 32'd1);
        wait_idle(50);
        chk("par_rx_byte", 32'(rx_b[base]), 32'h07);
`endif

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
